ecc_reg_scrubber: RTL
=====================

# ecc_reg_scrubber

Background scrub controller and write arbiter for a bank of `ecc_reg` SECDED registers. It periodically walks every register in the bank and samples its error flags. Registers with a correctable error are rewritten with their corrected data. The block also shares the bank's single write port between the host and the scrub engine. It sits between the host register-write path and the array of `ecc_reg` instances; an external combinational mux returns the selected register's data and flags.

## Interface
- `NUM_REGS`, 100, registers in the bank
- `NUM_REG_BITS`, 8, data width per register
- `SCRUB_INTERVAL`, 1024, idle cycles between scrub passes (≥2)
- `CNT_WIDTH`, 16, error-counter width
- `AW`, `$clog2(NUM_REGS)`, address width (derived)

Ports:
- `clk`  in  1  clock
- `reset_b`  in  1  reset; asynchronous, active-low
- `host_wr_req`  in  1  host write request
- `host_wr_addr`  in  AW  host target register
- `host_wr_data`  in  NUM_REG_BITS  host write data
- `host_wr_gnt`  out  1  host write accepted (combinational)
- `host_addr_err`  out  1  pulse: host address ≥ NUM_REGS, write dropped
- `scrub_en`  in  1  enable periodic scrubbing
- `scrub_addr`  out  AW  register selected for the read-back mux
- `sel_dout`  in  NUM_REG_BITS  corrected data of `scrub_addr`
- `sel_single_err`, `sel_double_err`, `sel_parity_err`  in  1 each  flags of `scrub_addr`
- `ecc_w_en`  out  NUM_REGS  one-hot write enables to the bank
- `ecc_w_din`  out  NUM_REG_BITS  write data broadcast to the bank
- `scrub_busy`  out  1  pass in progress
- `scrub_done`  out  1  pulse at end of pass
- `dbl_err_irq`  out  1  pulse on uncorrectable error
- `dbl_err_addr`  out  AW  address of last double error
- `single_cnt`, `double_cnt`  out  CNT_WIDTH  saturating error counts
- `cnt_clr`  in  1  synchronous clear of both counters

## Operation
- All outputs reset to 0. FSM resets to IDLE. The interval counter and `scrub_addr` reset to 0.
- Host path:
  - `host_wr_gnt = host_wr_req`. The host always has priority.
  - For an in-range address, the next cycle drives `ecc_w_en[addr]=1` and `ecc_w_din=data`.
  - For an out-of-range address, `host_addr_err` pulses next cycle and no enable is driven.
- FSM states and transitions:
  - IDLE: the interval counter increments while `scrub_en`=1 and holds at 0 while `scrub_en`=0. At `SCRUB_INTERVAL-1` the counter clears, `scrub_addr` is set to 0 and the FSM goes to READ.
  - READ: one cycle; `scrub_addr` settles at the mux. Go to CHECK.
  - CHECK: sample flags and `sel_dout`.
    - Double error: `double_cnt++`, `dbl_err_addr=scrub_addr`, `dbl_err_irq` pulse next cycle, no writeback, go to NEXT.
    - Single or parity error: `single_cnt++`, go to WB.
    - No error: go to NEXT.
  - WB: while `host_wr_req`=1, stay in WB. Otherwise issue a write of the sampled data to `scrub_addr` (registered, visible next cycle) and go to NEXT.
  - NEXT: if `scrub_addr==NUM_REGS-1` or `scrub_en`=0, pulse `scrub_done`, go to IDLE and reset `scrub_addr` to 0. Otherwise increment `scrub_addr` and go to READ.
- Supersede rule: a host write granted to `scrub_addr` in READ, CHECK or WB sets a hit flag. On hit, skip counting and writeback for that address and go to NEXT.
- Counters saturate at all-ones. `cnt_clr` has priority over an increment in the same cycle.
- `scrub_busy` is 1 in every state except IDLE.
- Deasserting `scrub_en` mid-pass completes the current register and then ends the pass.
- Reset asserted mid-pass aborts immediately; no partial write is emitted.

## Timing
- Host write: request at cycle N → `ecc_w_en` asserted in cycle N+1 only.
- Per register, no error: 2 cycles (READ, CHECK) plus 1 (NEXT) = 3 cycles.
- Per register, with writeback: 4 cycles plus stall cycles.
- A clean pass takes `3*NUM_REGS` cycles from leaving IDLE to the `scrub_done` pulse.
- `ecc_w_en` is at most one-hot in every cycle. The host and scrub writes never collide.

## Configuration
- With `ECC_SCRUB_STATS_EN` defined: `single_cnt`, `double_cnt` and `cnt_clr` are functional.
- Without it: the counters are not built, both outputs are tied to 0, and `cnt_clr` is ignored. All ports remain present.
- Scrubbing, `dbl_err_irq` and `dbl_err_addr` are unaffected by the macro.

## Structure
- Package `ecc_scrub_pkg` holds:
  - the FSM state enum `scrub_state_e` (IDLE, READ, CHECK, WB, NEXT);
  - default parameter constants;
  - a saturating-increment function.
- One sub-module, `ecc_sat_counter`, is instantiated twice (single and double) under the macro.

## Test plan
- `SCRUB_INTERVAL`=4, `scrub_en`=1, all flags 0 → `scrub_done` at 4+300 cycles after reset release; `ecc_w_en` stays 0 throughout.
- Single error on register 37 with `sel_dout`=8'hA5 → `ecc_w_en[37]` for one cycle with `ecc_w_din`=8'hA5; `single_cnt`=1.
- Double error on register 99 → `dbl_err_irq` pulse, `dbl_err_addr`=99, `double_cnt`=1, no write to 99.
- Host holds `host_wr_req` during WB on register 5 → scrub write is deferred until the request drops. Host writes to register 5 before that → writeback is cancelled (superseded).
- Host write to address 120 → `host_wr_gnt`=1, `host_addr_err` pulse, `ecc_w_en`=0.
- Other cases:
  - Reset asserted mid-pass → all outputs read 0 immediately.
  - Counter at all-ones plus an error → holds.
  - `cnt_clr` together with an error → 0.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the ECC register scrubber.
// Holds the FSM state enum, default parameters and a saturating-increment helper.
package ecc_scrub_pkg;

  localparam int unsigned DEF_NUM_REGS       = 100;
  localparam int unsigned DEF_NUM_REG_BITS   = 8;
  localparam int unsigned DEF_SCRUB_INTERVAL = 1024;
  localparam int unsigned DEF_CNT_WIDTH      = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WB    = 3'd3,
    NEXT  = 3'd4
  } scrub_state_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module ecc_sat_counter
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = WIDTH'(sat_inc(64'(count_q), WIDTH));
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ecc_reg_scrubber.sv
// Background scrubber and single-write-port arbiter for a bank of SECDED registers.
// Error counters are built only when ECC_SCRUB_STATS_EN is defined; otherwise they read 0.
module ecc_reg_scrubber
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
  parameter int unsigned NUM_REG_BITS   = DEF_NUM_REG_BITS,
  parameter int unsigned SCRUB_INTERVAL = DEF_SCRUB_INTERVAL,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned AW             = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    host_wr_req,
  input  logic [AW-1:0]           host_wr_addr,
  input  logic [NUM_REG_BITS-1:0] host_wr_data,
  output logic                    host_wr_gnt,
  output logic                    host_addr_err,
  input  logic                    scrub_en,
  output logic [AW-1:0]           scrub_addr,
  input  logic [NUM_REG_BITS-1:0] sel_dout,
  input  logic                    sel_single_err,
  input  logic                    sel_double_err,
  input  logic                    sel_parity_err,
  output logic [NUM_REGS-1:0]     ecc_w_en,
  output logic [NUM_REG_BITS-1:0] ecc_w_din,
  output logic                    scrub_busy,
  output logic                    scrub_done,
  output logic                    dbl_err_irq,
  output logic [AW-1:0]           dbl_err_addr,
  output logic [CNT_WIDTH-1:0]    single_cnt,
  output logic [CNT_WIDTH-1:0]    double_cnt,
  input  logic                    cnt_clr
);

  localparam int unsigned IW = $clog2(SCRUB_INTERVAL);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_READ  = READ;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_WB    = WB;
  localparam logic [2:0] ST_NEXT  = NEXT;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_REGS - 1);
  localparam logic [AW:0]   NUM_REGS_W = (AW + 1)'(NUM_REGS);
  localparam logic [IW-1:0] INT_LAST   = IW'(SCRUB_INTERVAL - 1);

  logic [2:0]              state_q, state_d;
  logic [IW-1:0]           int_cnt_q, int_cnt_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    hit_q, hit_d;
  logic [NUM_REG_BITS-1:0] wb_data_q, wb_data_d;
  logic [AW-1:0]           dbl_addr_q, dbl_addr_d;
  logic                    done_q, done_d;
  logic                    irq_q, irq_d;
  logic [NUM_REGS-1:0]     w_en_q;
  logic [NUM_REG_BITS-1:0] w_din_q;
  logic                    addr_err_q;

  logic host_in_range;
  logic host_hit;
  logic scrub_wr;
  logic single_inc;
  logic double_inc;

  assign host_in_range = {1'b0, host_wr_addr} < NUM_REGS_W;
  // A granted host write to the register under scrub makes the sampled copy stale.
  assign host_hit      = host_wr_req && (host_wr_addr == addr_q);

  always_comb begin
    state_d    = state_q;
    int_cnt_d  = int_cnt_q;
    addr_d     = addr_q;
    hit_d      = hit_q;
    wb_data_d  = wb_data_q;
    dbl_addr_d = dbl_addr_q;
    done_d     = 1'b0;
    irq_d      = 1'b0;
    scrub_wr   = 1'b0;
    single_inc = 1'b0;
    double_inc = 1'b0;

    if ((state_q inside {ST_READ, ST_CHECK, ST_WB}) && host_hit) begin
      hit_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!scrub_en) begin
          int_cnt_d = '0;
        end else if (int_cnt_q == INT_LAST) begin
          int_cnt_d = '0;
          addr_d    = '0;
          hit_d     = 1'b0;
          state_d   = ST_READ;
        end else begin
          int_cnt_d = int_cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        wb_data_d = sel_dout;
        if (hit_q || host_hit) begin
          state_d = ST_NEXT;
        end else if (sel_double_err) begin
          double_inc = 1'b1;
          dbl_addr_d = addr_q;
          irq_d      = 1'b1;
          state_d    = ST_NEXT;
        end else if (sel_single_err || sel_parity_err) begin
          single_inc = 1'b1;
          state_d    = ST_WB;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WB: begin
        if (hit_q || host_hit) begin
          state_d = ST_NEXT;
        end else if (!host_wr_req) begin
          scrub_wr = 1'b1;
          state_d  = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if ((addr_q == LAST_ADDR) || !scrub_en) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          hit_d   = 1'b0;
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      int_cnt_q  <= '0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      wb_data_q  <= '0;
      dbl_addr_q <= '0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_cnt_q  <= int_cnt_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      wb_data_q  <= wb_data_d;
      dbl_addr_q <= dbl_addr_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
    end
  end

  // Scrub writes only issue while the host is idle, so the two sources never overlap.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      w_en_q     <= '0;
      w_din_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      w_en_q     <= '0;
      addr_err_q <= host_wr_req && !host_in_range;
      if (host_wr_req && host_in_range) begin
        w_en_q  <= NUM_REGS'(1) << host_wr_addr;
        w_din_q <= host_wr_data;
      end else if (scrub_wr) begin
        w_en_q  <= NUM_REGS'(1) << addr_q;
        w_din_q <= wb_data_q;
      end
    end
  end

`ifdef ECC_SCRUB_STATS_EN
  ecc_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_single_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (cnt_clr),
    .inc     (single_inc),
    .count   (single_cnt)
  );

  ecc_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_double_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (cnt_clr),
    .inc     (double_inc),
    .count   (double_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = ^{cnt_clr, single_inc, double_inc};
  assign single_cnt   = '0;
  assign double_cnt   = '0;
`endif

  assign host_wr_gnt   = host_wr_req;
  assign host_addr_err = addr_err_q;
  assign scrub_addr    = addr_q;
  assign ecc_w_en      = w_en_q;
  assign ecc_w_din     = w_din_q;
  assign scrub_busy    = (state_q != ST_IDLE);
  assign scrub_done    = done_q;
  assign dbl_err_irq   = irq_q;
  assign dbl_err_addr  = dbl_addr_q;

endmodule
